// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: pipeline request/response and data-memory bus bundle.
// master = pipeline + memory side, slave = mem_access_ctrl.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_wr;
  logic        dm_rd;
  logic [1:0]  dm_mux_sel;
  logic [63:0] dm_rdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned,
    output req_addr, req_wdata, dm_rdata,
    input  req_ready, dm_addr, dm_wdata, dm_wr, dm_rd,
    input  dm_mux_sel, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned,
    input  req_addr, req_wdata, dm_rdata,
    output req_ready, dm_addr, dm_wdata, dm_wr, dm_rd,
    output dm_mux_sel, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store sequencer with RMW for sub-double RAM stores.
// Ports: clk, rst_n (async, active low), bus (slave of mem_access_ctrl_if).
// Optional MEM_ACCESS_ALIGN_CHECK_EN: misaligned requests answer with error.
module mem_access_ctrl (
  input logic              clk,
  input logic              rst_n,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_RD, WRITE, RESP
  } state_e;

  localparam logic [1:0] RG_RAM = 2'd0;
  localparam logic [1:0] RG_LED = 2'd1;
  localparam logic [1:0] RG_SW  = 2'd2;
  localparam logic [1:0] RG_UNM = 2'd3;

  state_e      state_q;
  logic [1:0]  size_q;
  logic [1:0]  region_q;
  logic        uns_q;
  logic [63:0] wdata_q;
  logic        req_ready_q;
  logic        dm_wr_q;
  logic        dm_rd_q;
  logic [1:0]  dm_mux_sel_q;
  logic [63:0] dm_addr_q;
  logic [63:0] dm_wdata_q;
  logic        resp_valid_q;
  logic [63:0] resp_rdata_q;
  logic        resp_err_q;

  logic [1:0]  region_d;
  logic [1:0]  mux_d;
  logic        misal_d;
  logic        st_rmw_d;
  logic        st_wr_d;

  assign region_d = bus.req_addr[13:12];

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  logic [2:0] amask;
  always_comb begin
    amask = 3'b000;
    unique case (bus.req_size)
      2'd0:    amask = 3'b000;
      2'd1:    amask = 3'b001;
      2'd2:    amask = 3'b011;
      default: amask = 3'b111;
    endcase
  end
  assign misal_d = |(bus.req_addr[2:0] & amask);
`else
  assign misal_d = 1'b0;
`endif

  always_comb begin
    mux_d = 2'd0;
    unique case (1'b1)
      (region_d == RG_LED): mux_d = 2'd1;
      (region_d == RG_SW):  mux_d = 2'd2;
      default:              mux_d = 2'd0;
    endcase
  end

  assign st_rmw_d = (region_d == RG_RAM) &&
                    (bus.req_size != 2'd3);
  assign st_wr_d  = (region_d == RG_RAM) ||
                    (region_d == RG_LED);

  // Big-endian window: the accessed field sits in the top bits.
  function automatic logic [63:0] load_ext(
    logic [63:0] w, logic [1:0] sz, logic uns
  );
    logic s;
    logic [63:0] r;
    s = ~uns & w[63];
    unique case (sz)
      2'd0:    r = {{56{s}}, w[63:56]};
      2'd1:    r = {{48{s}}, w[63:48]};
      2'd2:    r = {{32{s}}, w[63:32]};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] merge(
    logic [63:0] w, logic [63:0] wd, logic [1:0] sz
  );
    logic [63:0] r;
    unique case (sz)
      2'd0:    r = {wd[7:0],  w[55:0]};
      2'd1:    r = {wd[15:0], w[47:0]};
      2'd2:    r = {wd[31:0], w[31:0]};
      default: r = wd;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      size_q       <= 2'd0;
      region_q     <= RG_RAM;
      uns_q        <= 1'b0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      dm_wr_q      <= 1'b0;
      dm_rd_q      <= 1'b0;
      dm_mux_sel_q <= 2'd0;
      dm_addr_q    <= '0;
      dm_wdata_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            size_q      <= bus.req_size;
            region_q    <= region_d;
            uns_q       <= bus.req_unsigned;
            wdata_q     <= bus.req_wdata;
            dm_addr_q   <= bus.req_addr;
            req_ready_q <= 1'b0;
            if (misal_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (!bus.req_we) begin
              state_q      <= LOAD;
              dm_rd_q      <= 1'b1;
              dm_mux_sel_q <= mux_d;
            end else if (st_rmw_d) begin
              state_q <= RMW_RD;
              dm_rd_q <= 1'b1;
            end else if (st_wr_d) begin
              state_q    <= WRITE;
              dm_wr_q    <= 1'b1;
              dm_wdata_q <= bus.req_wdata;
            end else begin
              // switch/unmapped store: dropped
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end
          end
        end
        LOAD: begin
          state_q      <= RESP;
          dm_rd_q      <= 1'b0;
          dm_mux_sel_q <= 2'd0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= (region_q == RG_UNM) ? '0 :
                          load_ext(bus.dm_rdata, size_q, uns_q);
        end
        RMW_RD: begin
          state_q    <= WRITE;
          dm_rd_q    <= 1'b0;
          dm_wr_q    <= 1'b1;
          dm_wdata_q <= merge(bus.dm_rdata, wdata_q, size_q);
        end
        WRITE: begin
          state_q      <= RESP;
          dm_wr_q      <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
        RESP: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          dm_addr_q    <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.dm_wr      = dm_wr_q;
  assign bus.dm_rd      = dm_rd_q;
  assign bus.dm_mux_sel = dm_mux_sel_q;
  assign bus.dm_addr    = dm_addr_q;
  assign bus.dm_wdata   = dm_wdata_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: random + directed bench with byte-level reference model.
// Scoreboard queue filled at issue, drained by a negedge monitor.
module tb_mem_access_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus();
  mem_access_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [63:0] SW_VAL = 64'hC3A5_0F1E_8D7B_6942;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [63:0] wdata;
    logic [63:0] addr;
    logic [1:0]  mux;
    int          acc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] env_ram [4096];
  logic [7:0] env_led;
  logic [7:0] ref_ram [4096];
  logic [7:0] ref_led;
  exp_t sb[$];
  exp_t me;
  logic [63:0] last_rdata;
  logic wr_seen;
  int nrd, nwr;

  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] env_win(logic [1:0] sel, logic [63:0] a);
    logic [63:0] w = '0;
    if (sel == 2'd1) w = {env_led, 56'h0};
    else if (sel == 2'd2) w = SW_VAL;
    else for (int i = 0; i < 8; i++)
      w = {w[55:0], env_ram[a[11:0] + 12'(i)]};
    return w;
  endfunction

  function automatic logic [63:0] ref_win(logic [63:0] a);
    logic [63:0] w = '0;
    case (a[13:12])
      2'd0: for (int i = 0; i < 8; i++)
              w = {w[55:0], ref_ram[a[11:0] + 12'(i)]};
      2'd1: w = {ref_led, 56'h0};
      2'd2: w = SW_VAL;
      default: w = '0;
    endcase
    return w;
  endfunction

  // Memory + peripherals seen by the DUT; updated away from the clock edge.
  always @(negedge clk) begin
    if (rst_n && bus.dm_wr) begin
      if (bus.dm_addr[13:12] == 2'd0)
        for (int i = 0; i < 8; i++)
          env_ram[bus.dm_addr[11:0] + 12'(i)] = bus.dm_wdata[63-8*i -: 8];
      else if (bus.dm_addr[13:12] == 2'd1)
        env_led = bus.dm_wdata[7:0];
    end
    bus.dm_rdata = env_win(bus.dm_mux_sel, bus.dm_addr);
  end

  function automatic exp_t predict(logic we, logic [1:0] sz, logic uns,
                                   logic [63:0] a, logic [63:0] wd);
    exp_t e;
    int nb = 1 << sz;
    int bits = 8 * nb;
    logic [1:0] rg = a[13:12];
    logic [63:0] f;
    e = '{rdata: 0, err: 0, lat: 1, nrd: 0, nwr: 0,
          wdata: 0, addr: a, mux: 0, acc: 0};
    e.mux = (rg == 2'd1) ? 2'd1 : (rg == 2'd2) ? 2'd2 : 2'd0;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if ((a & 64'(nb - 1)) != 0) begin
      e.err = 1'b1;
      return e;
    end
`endif
    if (!we) begin
      e.lat = 2;
      e.nrd = 1;
      if (rg != 2'd3) begin
        f = ref_win(a) >> (64 - bits);
        if (bits < 64 && !uns && f[bits-1])
          f = f | ~((64'd1 << bits) - 64'd1);
        e.rdata = f;
      end
    end else if (rg == 2'd0) begin
      for (int i = 0; i < nb; i++)
        ref_ram[a[11:0] + 12'(i)] = wd[8*(nb-1-i) +: 8];
      e.wdata = ref_win(a);
      e.nwr = 1;
      e.nrd = (nb < 8) ? 1 : 0;
      e.lat = (nb < 8) ? 3 : 2;
    end else if (rg == 2'd1) begin
      ref_led = wd[7:0];
      e.wdata = wd;
      e.nwr = 1;
      e.lat = 2;
    end else begin
      e.err = 1'b1;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      nrd = 0;
      nwr = 0;
      last_rdata = '0;
    end else begin
      if (bus.dm_wr) wr_seen = 1'b1;
      if (bus.dm_wr && bus.dm_rd) chk("strobe_overlap", 1, 0);
      if (bus.req_ready) begin
        chk("idle_strobes", {bus.dm_wr, bus.dm_rd}, 0);
        chk("idle_addr", bus.dm_addr, 0);
        chk("rdata_hold", bus.resp_rdata, last_rdata);
      end
      if (bus.dm_rd || bus.dm_wr || bus.resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_activity", 1, 0);
        end else begin
          if (bus.dm_rd) begin
            nrd++;
            chk("rd_addr", bus.dm_addr, sb[0].addr);
            chk("rd_mux", bus.dm_mux_sel, sb[0].mux);
          end
          if (bus.dm_wr) begin
            nwr++;
            chk("wr_addr", bus.dm_addr, sb[0].addr);
            chk("wr_data", bus.dm_wdata, sb[0].wdata);
          end
          if (bus.resp_valid) begin
            me = sb.pop_front();
            chk("resp_rdata", bus.resp_rdata, me.rdata);
            chk("resp_err", bus.resp_err, me.err);
            chk("latency", cyc - me.acc, me.lat);
            chk("rd_cycles", nrd, me.nrd);
            chk("wr_cycles", nwr, me.nwr);
            last_rdata = me.rdata;
            nrd = 0;
            nwr = 0;
          end
        end
      end
    end
  end

  task automatic issue(logic we, logic [1:0] sz, logic uns,
                       logic [63:0] a, logic [63:0] wd);
    exp_t e;
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("issue_timeout", 0, 1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_size = sz;
    bus.req_unsigned = uns;
    bus.req_addr = a;
    bus.req_wdata = wd;
    e = predict(we, sz, uns, a, wd);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if ($urandom_range(0, 1) == 1) begin
      // junk while busy must be ignored
      bus.req_we = 1'($urandom);
      bus.req_addr = {$urandom, $urandom};
      bus.req_wdata = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic preload(logic [11:0] a, logic [63:0] v);
    for (int i = 0; i < 8; i++) begin
      env_ram[a + 12'(i)] = v[63-8*i -: 8];
      ref_ram[a + 12'(i)] = v[63-8*i -: 8];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] snap;
    logic [63:0] a;
    logic [1:0] rg;
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_size = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    wr_seen = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      env_ram[i] = 8'($urandom);
      ref_ram[i] = env_ram[i];
    end
    env_led = 8'h00;
    ref_led = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {bus.dm_wr, bus.dm_rd}, 0);
    chk("rst_mux", bus.dm_mux_sel, 0);
    chk("rst_addr", bus.dm_addr, 0);
    chk("rst_wdata", bus.dm_wdata, 0);
    chk("rst_resp", {bus.resp_valid, bus.resp_err}, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", bus.req_ready, 1);

    preload(12'h010, 64'h8001_0203_0405_0607);
    issue(0, 2'd0, 0, 64'h10, 0);
    issue(0, 2'd0, 1, 64'h10, 0);
    preload(12'h020, 64'h1122_3344_5566_7788);
    issue(1, 2'd1, 0, 64'h20, 64'hABCD);
    issue(0, 2'd3, 0, 64'h20, 0);
    issue(1, 2'd0, 0, 64'h1000, 64'h5A);
    issue(0, 2'd0, 1, 64'h1000, 0);
    issue(1, 2'd2, 0, 64'h2000, 64'h1234_5678);
    issue(1, 2'd3, 0, 64'h3000, 64'h1);
    issue(0, 2'd1, 0, 64'h3008, 0);
    issue(0, 2'd2, 0, 64'h2004, 0);
    issue(0, 2'd2, 1, 64'h13, 0);
    issue(0, 2'd2, 0, 64'h13, 0);
    issue(1, 2'd3, 0, 64'h48, 64'hFEDC_BA98_7654_3210);
    issue(0, 2'd3, 0, 64'h48, 0);

    for (int k = 0; k < 300; k++) begin
      rg = ($urandom_range(0, 5) > 3) ? 2'd0 : 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      a[13:12] = rg;
      if ($urandom_range(0, 1) == 1) a[11:0] = 12'($urandom_range(0, 63));
      issue(1'($urandom), 2'($urandom), 1'($urandom), a,
            {$urandom, $urandom});
    end
    drain();

    // reset while the RMW read is in flight
    for (int i = 0; i < 8; i++) snap = {snap[55:0], env_ram[12'h040 + 12'(i)]};
    @(negedge clk);
    wr_seen = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we = 1'b1;
    bus.req_size = 2'd1;
    bus.req_unsigned = 1'b0;
    bus.req_addr = 64'h40;
    bus.req_wdata = 64'h9999;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_write", wr_seen, 0);
    chk("abort_ram", env_win(2'd0, 64'h40), snap);
    chk("abort_ready", bus.req_ready, 1);
    issue(0, 2'd3, 0, 64'h40, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock, all state changes on rising edge.
REQ-002 The block SHALL have these ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have these ports: req_valid, input, 1, access request from the pipeline.
REQ-004 The block SHALL have these ports: req_ready, output, 1, high only in IDLE.
REQ-005 The block SHALL have these ports: req_we, input, 1, 1=store, 0=load.
REQ-006 The block SHALL have these ports: req_size, input, 2, 0=byte, 1=half, 2=word, 3=double.
REQ-007 The block SHALL have these ports: req_unsigned, input, 1, zero-extend loads when 1, sign-extend when 0.
REQ-008 The block SHALL have these ports: req_addr, input, 64, byte address.
REQ-009 The block SHALL have these ports: req_wdata, input, 64, store data, right-aligned.
REQ-010 The block SHALL have these ports: dm_addr, output, 64, address to the data memory.
REQ-011 The block SHALL have these ports: dm_wdata, output, 64, write data to the data memory.
REQ-012 The block SHALL have these ports: dm_wr and dm_rd, output, 1 each, memory write and read strobes.
REQ-013 The block SHALL have these ports: dm_mux_sel, output, 2, memory output select: 0=RAM, 1=LED, 2=switches.
REQ-014 The block SHALL have these ports: dm_rdata, input, 64, combinational memory read data, big-endian 8-byte window starting at dm_addr.
REQ-015 The block SHALL have these ports: resp_valid, output, 1, one-cycle completion pulse.
REQ-016 The block SHALL have these ports: resp_rdata, output, 64, extended load result.
REQ-017 The block SHALL have these ports: resp_err, output, 1, error flag valid with resp_valid.

Function
REQ-018 A request SHALL be accepted on a rising edge with req_valid=1 and req_ready=1; all req_* fields are latched then, and req_valid while not ready is ignored.
REQ-019 The region SHALL be decoded from latched addr[13:12]: 00=RAM, 01=LED, 10=switches, 11=unmapped.
REQ-020 The FSM states SHALL be IDLE, LOAD, RMW_RD, WRITE, RESP.
REQ-021 From IDLE on acceptance, the FSM SHALL go to LOAD for a load, RMW_RD for a RAM store with size<3, WRITE for a double RAM store or any LED store, and RESP for a switch or unmapped store, which is discarded.
REQ-022 In LOAD the block SHALL assert dm_rd=1 with dm_mux_sel per region (RAM=0, LED=1, switches=2, unmapped=0), capture dm_rdata at end of cycle, and go to RESP.
REQ-023 For loads, the extracted field SHALL be the top bits of dm_rdata: byte [63:56], half [63:48], word [63:32], double [63:0], then extended per req_unsigned into 64 bits.
REQ-024 In RMW_RD the block SHALL assert dm_rd=1, capture dm_rdata into a merge register, and go to WRITE.
REQ-025 The merge SHALL replace the top 8/16/32 bits of the captured window with req_wdata[7:0]/[15:0]/[31:0] and leave the remaining bytes unchanged.
REQ-026 In WRITE the block SHALL assert dm_wr=1 for exactly one cycle, with dm_wdata = merged value (RMW) or req_wdata (double/LED), then go to RESP.
REQ-027 In RESP the block SHALL pulse resp_valid=1 for one cycle and return to IDLE; resp_rdata holds its value until the next load response, and is 0 after any store response.
REQ-028 Unmapped loads SHALL return resp_rdata=0; unmapped or switch-region stores SHALL set resp_err=1.
REQ-029 dm_addr SHALL equal the latched address in all non-IDLE states and 0 in IDLE.
REQ-030 dm_wr and dm_rd SHALL never be high together, and both SHALL be 0 in IDLE and RESP.
REQ-031 Latency from acceptance to resp_valid SHALL be: load 2 cycles, sub-double RAM store 3, double/LED store 2, discarded store 1.
REQ-032 A new request SHALL be acceptable in the cycle after RESP, giving back-to-back throughput of one access per latency+1 cycles.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE, dm_wr=0, dm_rd=0, dm_mux_sel=0, dm_addr=0, dm_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 after release.
REQ-034 Reset during RMW_RD or LOAD SHALL abort with no memory write and no response; reset during WRITE SHALL suppress resp_valid.

Configuration
REQ-035 With MEM_ACCESS_ALIGN_CHECK_EN defined, a request whose addr is not a multiple of 2^req_size SHALL go IDLE->RESP with no memory strobe, resp_err=1, resp_rdata=0.
REQ-036 Without MEM_ACCESS_ALIGN_CHECK_EN, alignment SHALL be unchecked: misaligned accesses proceed normally using the big-endian window at addr, and resp_err reflects only REQ-028.

Verification
REQ-037 Signed byte load: RAM bytes 0x10..0x17 = 80 01 02 03 04 05 06 07, load byte addr 0x10, unsigned=0 -> resp_rdata=0xFFFF_FFFF_FFFF_FF80 two cycles after accept; with unsigned=1 -> 0x80.
REQ-038 Half store RMW: window at 0x20 = 0x1122334455667788, store half 0xABCD at 0x20 -> one dm_rd cycle then one dm_wr cycle with dm_wdata=0xABCD334455667788; resp_valid 3 cycles after accept.
REQ-039 LED store: store byte 0x5A at 0x1000 -> single dm_wr with dm_wdata[7:0]=0x5A and no dm_rd; subsequent load byte at 0x1000 -> dm_mux_sel=1, resp_rdata=0x5A.
REQ-040 Switch store: store at 0x2000 -> no dm_wr/dm_rd, resp_valid next cycle with resp_err=1.
REQ-041 Reset mid-RMW: assert rst_n=0 during RMW_RD -> dm_wr never asserts, memory unchanged, no resp_valid, req_ready=1 after release.
REQ-042 With MEM_ACCESS_ALIGN_CHECK_EN, load word at 0x13 -> no strobes, resp_err=1; without it -> load returns bytes 0x13..0x16.
